// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//
// Writer side of the instruction memory. Program bytes arrive over a
// valid/ready byte stream. Every four accepted bytes are packed into one
// little-endian 32-bit word, which is then written to instruction memory
// through a word-aligned byte-address write port. A load always writes
// words 0 .. MEM_SIZE-1 in order, and the CPU is held stalled for as long
// as a load is in progress.
//
// Ports
//   i_clk          rising-edge clock for all logic
//   i_rst_n        synchronous, active-low reset
//   i_start        begin a load (only looked at while idle)
//   i_byte_in      program byte
//   i_byte_valid   i_byte_in carries a byte
//   o_byte_ready   loader takes a byte this cycle
//   o_wr_en        memory write strobe, one cycle per word
//   o_wr_address   byte address of the word being written (bits[1:0] = 0)
//   o_wr_data      assembled word, first received byte in bits [7:0]
//   o_busy         a load is in progress
//   o_cpu_stall    same as o_busy
//   o_done         one-cycle pulse after the last word has been written
//   o_word_count   words written so far in the current / last load
// ---------------------------------------------------------------------------
module inst_mem_loader #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_SIZE      = 10,
   localparam int COUNT_WIDTH  = $clog2(MEM_SIZE + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [7:0]               i_byte_in,
   input  logic                     i_byte_valid,
   output logic                     o_byte_ready,
   output logic                     o_wr_en,
   output logic [ADDRESS_WIDTH-1:0] o_wr_address,
   output logic [DATA_WIDTH-1:0]    o_wr_data,
   output logic                     o_busy,
   output logic                     o_cpu_stall,
   output logic                     o_done,
   output logic [COUNT_WIDTH-1:0]   o_word_count
);

   typedef enum logic [1:0] {
      IDLE,
      ASSEMBLE,
      WRITE,
      DONE
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] LAST_WORD = COUNT_WIDTH'(MEM_SIZE - 1);

   state_t                   r_state;
   logic [1:0]               r_byteIdx;
   logic [COUNT_WIDTH-1:0]   r_wordIdx;
   logic [COUNT_WIDTH-1:0]   r_wordCount;
   logic [31:0]              r_partial;
   logic                     r_byteReady;
   logic                     r_wrEn;
   logic [ADDRESS_WIDTH-1:0] r_wrAddress;
   logic [DATA_WIDTH-1:0]    r_wrData;
   logic                     r_busy;
   logic                     r_done;

   logic [ADDRESS_WIDTH-1:0] w_wordAddress;

   // Word index scaled to a byte address; the two low bits are always zero.
   assign w_wordAddress = ADDRESS_WIDTH'({r_wordIdx, 2'b00});

   // Single FSM block. Every output is a register that is updated together
   // with the state it belongs to, so o_byte_ready is already low in the
   // WRITE cycle and o_busy drops exactly when IDLE is re-entered.
   // While assembling, o_byte_ready is high, so i_byte_valid alone marks a
   // handshake. The fourth byte skips the partial register and goes straight
   // into the output word, which is why the write can follow on the very
   // next cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_byteIdx   <= '0;
         r_wordIdx   <= '0;
         r_wordCount <= '0;
         r_partial   <= '0;
         r_byteReady <= 1'b0;
         r_wrEn      <= 1'b0;
         r_wrAddress <= '0;
         r_wrData    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state     <= ASSEMBLE;
                  r_byteIdx   <= '0;
                  r_wordIdx   <= '0;
                  r_wordCount <= '0;
                  r_byteReady <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end

            ASSEMBLE: begin
               if (i_byte_valid) begin
                  if (r_byteIdx == 2'd3) begin
                     r_wrData    <= DATA_WIDTH'({i_byte_in, r_partial[23:0]});
                     r_wrAddress <= w_wordAddress;
                     r_wrEn      <= 1'b1;
                     r_byteReady <= 1'b0;
                     r_state     <= WRITE;
                  end else begin
                     r_partial[8*r_byteIdx +: 8] <= i_byte_in;
                  end
                  r_byteIdx <= r_byteIdx + 2'd1;
               end
            end

            WRITE: begin
               r_wrEn      <= 1'b0;
               r_wordCount <= r_wordCount + COUNT_WIDTH'(1);
               if (r_wordIdx == LAST_WORD) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_wordIdx   <= r_wordIdx + COUNT_WIDTH'(1);
                  r_byteIdx   <= '0;
                  r_byteReady <= 1'b1;
                  r_state     <= ASSEMBLE;
               end
            end

            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_byte_ready = r_byteReady;
   assign o_wr_en      = r_wrEn;
   assign o_wr_address = r_wrAddress;
   assign o_wr_data    = r_wrData;
   assign o_busy       = r_busy;
   assign o_cpu_stall  = r_busy;
   assign o_done       = r_done;
   assign o_word_count = r_wordCount;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Randomised bench for inst_mem_loader. A behavioural model follows the
// loader's rules with a byte queue and a few counters. Every cycle the DUT
// outputs are compared against the model. Directed scenarios cover:
//   - reset
//   - the first word of a load
//   - a full load with continuous valid
//   - toggled valid
//   - start pulsed in the middle of a load
//   - reset in the middle of a load
// Random loads follow the directed scenarios.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

   localparam int MEM_SIZE = 10;
   localparam int CW       = $clog2(MEM_SIZE + 1);

   logic          clk = 1'b0;
   logic          rstN;
   logic          start;
   logic [7:0]    byteIn;
   logic          byteValid;
   logic          byteReady;
   logic          wrEn;
   logic [31:0]   wrAddress;
   logic [31:0]   wrData;
   logic          busy;
   logic          cpuStall;
   logic          done;
   logic [CW-1:0] wordCount;

   int checks = 0;
   int errors = 0;

   // Model state. The model tracks a load as follows:
   //   - accepted bytes wait in a queue;
   //   - a full queue becomes one pending write;
   //   - after the last write comes one done cycle.
   logic [7:0]  mBytes[$];
   bit          mBusy;
   bit          mWriteCycle;
   bit          mDoneCycle;
   int          mWords;
   int          mCount;
   logic [31:0] mLastAddr;
   logic [31:0] mLastData;

   logic [7:0]  prog[4*MEM_SIZE];

   inst_mem_loader #(
      .DATA_WIDTH(32),
      .ADDRESS_WIDTH(32),
      .MEM_SIZE(MEM_SIZE)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_start(start),
      .i_byte_in(byteIn),
      .i_byte_valid(byteValid),
      .o_byte_ready(byteReady),
      .o_wr_en(wrEn),
      .o_wr_address(wrAddress),
      .o_wr_data(wrData),
      .o_busy(busy),
      .o_cpu_stall(cpuStall),
      .o_done(done),
      .o_word_count(wordCount)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Counts the comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advances the model across one rising edge, using the inputs that were
   // applied during the preceding cycle.
   task automatic modelStep(input logic st, input logic vld, input logic [7:0] b, input logic rn);
      if (!rn) begin
         mBytes.delete();
         mBusy = 0; mWriteCycle = 0; mDoneCycle = 0;
         mWords = 0; mCount = 0; mLastAddr = 0; mLastData = 0;
      end else if (!mBusy) begin
         if (st) begin
            mBusy = 1; mWords = 0; mCount = 0;
            mBytes.delete();
         end
      end else if (mDoneCycle) begin
         mDoneCycle = 0;
         mBusy = 0;
      end else if (mWriteCycle) begin
         mWriteCycle = 0;
         mCount++;
         mWords++;
         if (mWords == MEM_SIZE) mDoneCycle = 1;
      end else if (vld) begin
         mBytes.push_back(b);
         if (mBytes.size() == 4) begin
            mLastData = {mBytes[3], mBytes[2], mBytes[1], mBytes[0]};
            mLastAddr = 32'(mWords * 4);
            mWriteCycle = 1;
            mBytes.delete();
         end
      end
   endtask

   // Compares every DUT output with the value the model predicts.
   task automatic compareAll();
      checkOutput("byteReady", 32'(byteReady), 32'(mBusy && !mWriteCycle && !mDoneCycle));
      checkOutput("wrEn",      32'(wrEn),      32'(mWriteCycle));
      checkOutput("wrAddress", wrAddress,      mLastAddr);
      checkOutput("wrData",    wrData,         mLastData);
      checkOutput("busy",      32'(busy),      32'(mBusy));
      checkOutput("cpuStall",  32'(cpuStall),  32'(mBusy));
      checkOutput("done",      32'(done),      32'(mDoneCycle));
      checkOutput("wordCount", 32'(wordCount), 32'(mCount));
   endtask

   // Drives one cycle of inputs, steps the model on the rising edge, and
   // checks the outputs half a cycle later.
   task automatic applyStimulus(input logic st, input logic vld, input logic [7:0] b, input logic rn);
      start = st; byteValid = vld; byteIn = b; rstN = rn;
      @(posedge clk);
      modelStep(st, vld, b, rn);
      @(negedge clk);
      compareAll();
   endtask

   task automatic fillProgram();
      for (int i = 0; i < 4*MEM_SIZE; i++) prog[i] = 8'($urandom);
   endtask

   // Feeds program bytes until the DUT pulses done, then runs one more cycle.
   // Arguments:
   //   validMode     0 = always valid, 1 = valid toggles each cycle, 2 = random valid
   //   restartWord   pulse start while this word is being assembled (-1 = never)
   //   abortWord,
   //   abortByte     assert reset once that many bytes of that word are in (-1 = never)
   //   doneAt        observation index of the done pulse; the start cycle's
   //                 observation counts as 1
   task automatic loadSequence(input int validMode, input int restartWord,
                               input int abortWord, input int abortByte, output int doneAt);
      int  obs = 1;
      bit  restarted = 0;
      logic vld;
      logic [7:0] b;
      int  idx;
      doneAt = -1;
      while (obs < 400) begin
         if (abortWord >= 0 && mWords == abortWord && mBytes.size() == abortByte && !mWriteCycle) begin
            applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0);
            return;
         end
         case (validMode)
            0:       vld = 1'b1;
            1:       vld = obs[0];
            default: vld = ($urandom_range(0, 3) != 0);
         endcase
         idx = mWords * 4 + mBytes.size();
         b = (idx < 4*MEM_SIZE && vld) ? prog[idx] : 8'($urandom);
         if (restartWord >= 0 && !restarted && mWords == restartWord) begin
            restarted = 1;
            applyStimulus(1'b1, vld, b, 1'b1);
         end else begin
            applyStimulus(1'b0, vld, b, 1'b1);
         end
         obs++;
         if (done === 1'b1) begin
            doneAt = obs;
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            return;
         end
      end
      checkOutput("loadTimeout", 32'(obs), 32'd0);
   endtask

   initial begin
      int doneAt;
      start = 0; byteValid = 0; byteIn = 0; rstN = 0;
      mBusy = 0; mWriteCycle = 0; mDoneCycle = 0;
      mWords = 0; mCount = 0; mLastAddr = 0; mLastData = 0;

      // Reset held for two cycles, with some input noise applied.
      applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

      // First word of a load. The byte presented alongside start must not be taken.
      fillProgram();
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h78, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h56, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h34, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'h12, 1'b1);
      checkOutput("firstWrEn",   32'(wrEn), 32'd1);
      checkOutput("firstAddr",   wrAddress, 32'h0);
      checkOutput("firstData",   wrData,    32'h12345678);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("firstCount",  32'(wordCount), 32'd1);
      loadSequence(2, -1, -1, -1, doneAt);

      // Full load with continuous valid; check the done latency and the final count.
      fillProgram();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      loadSequence(0, -1, -1, -1, doneAt);
      checkOutput("doneLatency", 32'(doneAt), 32'(1 + 5*MEM_SIZE));
      checkOutput("finalCount",  32'(wordCount), 32'(MEM_SIZE));
      checkOutput("idleStall",   32'(cpuStall), 32'd0);

      // Valid toggling every cycle.
      fillProgram();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      loadSequence(1, -1, -1, -1, doneAt);

      // Start pulsed again while word 3 is being assembled.
      fillProgram();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      loadSequence(2, 3, -1, -1, doneAt);

      // Reset after two bytes of word 5, then a fresh load starting at address 0.
      fillProgram();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      loadSequence(0, -1, 5, 2, doneAt);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortWrEn", 32'(wrEn), 32'd0);
      fillProgram();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
      loadSequence(0, -1, -1, -1, doneAt);

      // Random loads, each with a randomly chosen restart word.
      for (int n = 0; n < 4; n++) begin
         fillProgram();
         applyStimulus(1'b1, 1'($urandom), 8'($urandom), 1'b1);
         loadSequence(2, $urandom_range(0, MEM_SIZE - 1), -1, -1, doneAt);
         applyStimulus(1'b0, 1'($urandom), 8'($urandom), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
